// File: rtl/alu_exec_if.sv
// Upstream request and downstream result handshakes of the ALU execute stage.
// The master side issues operations and consumes results; the stage is the slave.
interface alu_exec_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_use_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    modport master (
        output in_valid, in_op, in_a, in_b, in_use_acc, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_use_acc, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Sequential execute stage in front of the combinational 8-bit ALU: registers operands,
// captures result/flags/compare outcome, keeps an accumulator and a sticky error bit.
module alu_exec_stage #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned FLAGS_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_exec_if.slave          bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_sel,
    input  logic [WIDTH-1:0]   alu_c,
    input  logic [FLAGS_W-1:0] alu_flags,
    input  logic [1:0]         alu_cmp,
    output logic [FLAGS_W-1:0] flags_q,
    output logic [1:0]         cmp_q,
    output logic [WIDTH-1:0]   acc_q,
    output logic               err_sticky,
    input  logic               clr_err
);
    localparam logic [3:0] OpDiv = 4'h3;
    localparam logic [3:0] OpMod = 4'h4;
    localparam logic [3:0] OpCmp = 4'h5;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q, state_d;
    logic             accept;
    logic             capture;
    logic             op_invalid;
    logic             op_cmp;
    logic             div_zero;
    logic             cap_err;
    logic [WIDTH-1:0] result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        capture       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                capture = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Opcodes E and F are undefined; the ALU output is ignored for them.
    assign op_invalid     = (alu_sel[3:1] == 3'b111);
    assign op_cmp         = (alu_sel == OpCmp);
    assign div_zero       = ((alu_sel == OpDiv) || (alu_sel == OpMod)) && (alu_b == '0);
    assign cap_err        = capture && (op_invalid || div_zero);
    assign bus.out_result = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            result_q <= '0;
            flags_q  <= '0;
            cmp_q    <= '0;
            acc_q    <= '0;
        end else begin
            if (accept) begin
                alu_a   <= bus.in_use_acc ? acc_q : bus.in_a;
                alu_b   <= bus.in_b;
                alu_sel <= bus.in_op;
            end
            if (capture) begin
                if (op_invalid) begin
                    result_q <= '0;
                    flags_q  <= '1;
                end else if (op_cmp) begin
                    result_q <= '0;
                    flags_q  <= alu_flags;
                    cmp_q    <= alu_cmp;
                end else begin
                    result_q <= alu_c;
                    flags_q  <= alu_flags;
                    acc_q    <= alu_c;
                end
            end
        end
    end

    // A capture error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (cap_err) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: a stand-in ALU model, a vector table fed
// through a scoreboard queue, and hand-written error, backpressure and reset sequences.
module tb_alu_exec_stage;
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
        logic [7:0] res;
        logic [6:0] flags;
        logic [1:0] cmp;
        logic [7:0] acc;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_a, alu_b, alu_c, acc_q;
    logic [3:0] alu_sel;
    logic [6:0] alu_flags, flags_q;
    logic [1:0] alu_cmp, cmp_q;
    logic       err_sticky, clr_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t exp_q[$];
    vec_t vecs[13];

    alu_exec_if #(.WIDTH(8)) bus ();

    alu_exec_stage #(.WIDTH(8), .FLAGS_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_c     (alu_c),
        .alu_flags (alu_flags),
        .alu_cmp   (alu_cmp),
        .flags_q   (flags_q),
        .cmp_q     (cmp_q),
        .acc_q     (acc_q),
        .err_sticky(err_sticky),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU. Flags {S,C,Z,P,O,I,D}; invalid ops return junk so ignoring it is visible.
    function automatic logic [16:0] alu_model(input logic [3:0] sel, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  c;
        logic        cy, ov;
        logic [6:0]  f;
        logic [1:0]  cm;
        s  = '0;
        p  = '0;
        c  = '0;
        cy = 1'b0;
        ov = 1'b0;
        cm = (a == b) ? 2'b00 : ((a > b) ? 2'b01 : 2'b10);
        case (sel)
            4'h0: begin
                s  = {1'b0, a} + {1'b0, b};
                c  = s[7:0];
                cy = s[8];
                ov = (a[7] == b[7]) && (c[7] != a[7]);
            end
            4'h1, 4'h5: begin
                s  = {1'b0, a} - {1'b0, b};
                c  = s[7:0];
                cy = s[8];
                ov = (a[7] != b[7]) && (c[7] != a[7]);
            end
            4'h2: begin
                p  = {8'h00, a} * {8'h00, b};
                c  = p[7:0];
                cy = |p[15:8];
                ov = cy;
            end
            4'h3: if (b == 8'h00) c = 8'hFF; else c = a / b;
            4'h4: if (b == 8'h00) c = 8'hFF; else c = a % b;
            4'h6: c = a & b;
            4'h7: c = a | b;
            4'h8: c = a ^ b;
            4'h9: c = ~a;
            4'hA: c = ~(a & b);
            4'hB: c = ~(a | b);
            4'hC: begin c = {a[6:0], 1'b0}; cy = a[7]; end
            4'hD: begin c = {1'b0, a[7:1]}; cy = a[0]; end
            default: c = 8'h5A;
        endcase
        f = {c[7], cy, (c == 8'h00), ~^c, ov, 2'b00};
        if ((sel == 4'h3 || sel == 4'h4) && b == 8'h00) f = 7'h7F;
        if (sel >= 4'hE) f = 7'h01;
        return {c, f, cm};
    endfunction

    always_comb {alu_c, alu_flags, alu_cmp} = alu_model(alu_sel, alu_a, alu_b);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare on every output handshake against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                vec_t e;
                e = exp_q.pop_front();
                check("out_result", 64'(bus.out_result), 64'(e.res));
                check("flags_q", 64'(flags_q), 64'(e.flags));
                check("cmp_q", 64'(cmp_q), 64'(e.cmp));
                check("acc_q", 64'(acc_q), 64'(e.acc));
                check("err_sticky", 64'(err_sticky), 64'(e.err));
            end
        end
    end

    // Issue one operation; returns at the falling edge where out_valid must be high.
    task automatic send(input vec_t v, input bit clr_in_exec);
        @(negedge clk);
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid   = 1'b1;
        bus.in_op      = v.op;
        bus.in_a       = v.a;
        bus.in_b       = v.b;
        bus.in_use_acc = v.use_acc;
        @(posedge clk);
        exp_q.push_back(v);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 8'($urandom);
        bus.in_b     = 8'($urandom);
        if (clr_in_exec) clr_err = 1'b1;
        @(negedge clk);
        check("latency_exec_not_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
        check("latency_done_valid", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic check_reset_state(input string name);
        check(name, {alu_a, alu_b, alu_sel, bus.out_result, flags_q, cmp_q, acc_q, err_sticky,
                     bus.out_valid}, 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic clear_err();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_cleared", 64'(err_sticky), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            op     a      b      acc   res    flags  cmp    acc_q  err
        vecs[0]  = '{4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 7'h44, 2'b00, 8'h80, 1'b0};
        vecs[1]  = '{4'h0, 8'h05, 8'h03, 1'b0, 8'h08, 7'h00, 2'b00, 8'h08, 1'b0};
        vecs[2]  = '{4'h2, 8'hEE, 8'h04, 1'b1, 8'h20, 7'h00, 2'b00, 8'h20, 1'b0};
        vecs[3]  = '{4'h1, 8'h10, 8'h20, 1'b0, 8'hF0, 7'h68, 2'b00, 8'hF0, 1'b0};
        vecs[4]  = '{4'h5, 8'h03, 8'h09, 1'b0, 8'h00, 7'h68, 2'b10, 8'hF0, 1'b0};
        vecs[5]  = '{4'h8, 8'h11, 8'hF0, 1'b1, 8'h00, 7'h18, 2'b10, 8'h00, 1'b0};
        vecs[6]  = '{4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 7'h38, 2'b10, 8'h00, 1'b0};
        vecs[7]  = '{4'hC, 8'h81, 8'h00, 1'b0, 8'h02, 7'h20, 2'b10, 8'h02, 1'b0};
        vecs[8]  = '{4'h3, 8'h64, 8'h07, 1'b0, 8'h0E, 7'h00, 2'b10, 8'h0E, 1'b0};
        vecs[9]  = '{4'h4, 8'hEE, 8'h05, 1'b1, 8'h04, 7'h00, 2'b10, 8'h04, 1'b0};
        vecs[10] = '{4'h5, 8'h09, 8'h09, 1'b0, 8'h00, 7'h18, 2'b00, 8'h04, 1'b0};
        vecs[11] = '{4'h6, 8'hF0, 8'h3C, 1'b0, 8'h30, 7'h08, 2'b00, 8'h30, 1'b0};
        vecs[12] = '{4'h5, 8'h09, 8'h03, 1'b0, 8'h00, 7'h08, 2'b01, 8'h30, 1'b0};

        rst_n          = 1'b0;
        clr_err        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_op      = 4'h0;
        bus.in_a       = 8'h00;
        bus.in_b       = 8'h00;
        bus.in_use_acc = 1'b0;
        bus.out_ready  = 1'b1;
        #12;
        check_reset_state("reset_regs");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) send(vecs[i], 1'b0);

        // Divide by zero sets the sticky error; accumulator takes the 0xFF result.
        v = '{4'h3, 8'h10, 8'h00, 1'b0, 8'hFF, 7'h7F, 2'b01, 8'hFF, 1'b1};
        send(v, 1'b0);
        clear_err();
        // Clear asserted on the capture edge of a new error: set wins.
        v = '{4'h4, 8'h22, 8'h00, 1'b0, 8'hFF, 7'h7F, 2'b01, 8'hFF, 1'b1};
        send(v, 1'b1);
        @(negedge clk);
        check("err_set_wins_after", 64'(err_sticky), 64'd1);
        clear_err();
        // Invalid opcode: ALU junk ignored, accumulator untouched.
        v = '{4'hE, 8'h12, 8'h34, 1'b0, 8'h00, 7'h7F, 2'b01, 8'hFF, 1'b1};
        send(v, 1'b0);
        clear_err();

        // Backpressure with a competing request that must be ignored.
        bus.out_ready = 1'b0;
        v = '{4'h0, 8'h20, 8'h22, 1'b0, 8'h42, 7'h08, 2'b01, 8'h42, 1'b0};
        send(v, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_op    = 4'h0;
            bus.in_a     = 8'h01;
            bus.in_b     = 8'h01;
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_result", 64'(bus.out_result), 64'h42);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_back_idle_ready", 64'(bus.in_ready), 64'd1);
        check("bp_back_idle_valid", 64'(bus.out_valid), 64'd0);
        v = '{4'h0, 8'h99, 8'h01, 1'b1, 8'h43, 7'h00, 2'b01, 8'h43, 1'b0};
        send(v, 1'b0);

        // Reset in the middle of EXEC aborts with no output.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 4'h0;
        bus.in_a     = 8'h11;
        bus.in_b     = 8'h22;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_state("reset_mid_exec");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_valid_after_reset", 64'(bus.out_valid), 64'd0);
        end
        v = '{4'h0, 8'h01, 8'h01, 1'b0, 8'h02, 7'h00, 2'b00, 8'h02, 1'b0};
        send(v, 1'b0);
        @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Sequential execute stage sitting directly upstream of the combinational 8-bit ALU.
- Accepts operations over a valid/ready handshake and drives the ALU operands and select.
- Captures result, flags and comparison outcome into registers, then presents the result downstream over a second valid/ready handshake.
- Adds an accumulator (chained operations), an architectural flags register and a sticky error bit for divide-by-zero and invalid opcodes.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU.
- FLAGS_W, 7, flag vector width. Bit map: 6 Sign, 5 Carry, 4 Zero, 3 Parity, 2 Overflow, 1 Interrupt, 0 Direction.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  stage can accept an operation
- in_op  in  4  ALU opcode: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp, 6-D logic, E/F invalid
- in_a  in  WIDTH  operand A, ignored when in_use_acc=1
- in_b  in  WIDTH  operand B
- in_use_acc  in  1  1: operand A comes from the accumulator
- alu_a  out  WIDTH  registered operand A to ALU
- alu_b  out  WIDTH  registered operand B to ALU
- alu_sel  out  4  registered opcode to ALU
- alu_c  in  WIDTH  ALU result
- alu_flags  in  FLAGS_W  ALU flags
- alu_cmp  in  2  ALU comparison result: 00 eq, 01 A>B, 10 A<B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  WIDTH  captured result
- flags_q  out  FLAGS_W  architectural flags register
- cmp_q  out  2  last comparison result
- acc_q  out  WIDTH  accumulator
- err_sticky  out  1  sticky error
- clr_err  in  1  synchronous clear of err_sticky

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output register is 0, i.e. alu_a, alu_b, alu_sel, out_result, flags_q, cmp_q, acc_q, err_sticky = 0; out_valid=0; in_ready=1. Reset mid-operation aborts the operation with no output.
- FSM states: IDLE, EXEC, DONE.
- in_ready = (state==IDLE).
- out_valid = (state==DONE).
- IDLE:
  - On in_valid&&in_ready: load alu_a (acc_q if in_use_acc, else in_a), alu_b=in_b, alu_sel=in_op; go to EXEC.
  - Otherwise hold.
- EXEC, exactly 1 cycle, ALU settles combinationally:
  - Capture at the end of the cycle, then go to DONE.
  - Ops 0-4, 6-D: out_result=alu_c; flags_q=alu_flags; acc_q=alu_c.
  - Op 5 (cmp): out_result=0x00; flags_q=alu_flags; cmp_q=alu_cmp; acc_q unchanged.
  - Op 3/4 with alu_b==0: captured as above (ALU returns 0xFF, flags 0x7F); err_sticky set.
  - Op E/F: ALU output is ignored; out_result=0x00; flags_q=0x7F; acc_q unchanged; err_sticky set.
- DONE:
  - Hold out_result stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE.
- Latency: accept edge T → out_valid high after edge T+1. Minimum 3 cycles per operation; no overlap.
- in_use_acc reads acc_q as updated by the previous completed operation (strict ordering guaranteed by the FSM).
- cmp_q changes only on op 5.
- flags_q changes only on capture.
- err_sticky:
  - Set on a capture error.
  - Cleared by clr_err in any state.
  - Set and clear in the same cycle: set wins.
- in_* changes while not accepted are ignored. alu_* outputs remain stable from EXEC through DONE.

Test Plan:
- Add: op0, A=0x7F, B=0x01 → out_result=0x80; flags_q[6]=1, [2]=1, [4]=0; acc_q=0x80; out_valid after edge T+1.
- Accumulator chain: op0 with A=0x05, B=0x03 → 0x08; then op2 with use_acc=1, B=0x04 → out_result=0x20, acc_q=0x20.
- Divide by zero: op3, A=0x10, B=0x00 → out_result=0xFF, flags_q=0x7F, err_sticky=1. Then clr_err → 0. Then clr_err asserted on the same cycle as a new error capture → err_sticky stays 1.
- Compare: op5, A=0x03, B=0x09 → cmp_q=10, out_result=0x00, acc_q unchanged. Invalid op E → flags_q=0x7F, err_sticky=1.
- Backpressure: hold out_ready=0 for 5 cycles → out_valid and out_result stable, in_ready=0, new in_valid ignored. Release → one handshake, return to IDLE.
- Reset mid-EXEC: deassert rst_n during EXEC → all outputs 0 immediately, in_ready=1, no out_valid pulse after reset release.
